// File: rtl/count_seq_checker_if.sv
// ---------------------------------------------------------------------------
// count_seq_checker_if
// Bundle between an observed up-counter (plus whoever watches the status) and
// the sequence checker.
//
// Signals:
//   in_valid     qualifies count_in this cycle       (master -> slave)
//   count_in     observed counter value              (master -> slave)
//   locked       checker is in LOCKED                (slave -> master)
//   err_pulse    one-cycle pulse per sequence error  (slave -> master)
//   error        sticky error flag                   (slave -> master)
//   err_count    saturating error count              (slave -> master)
//   wrap_pulse   one-cycle pulse on a legal max->0   (slave -> master)
//   wrap_count   modulo wrap count                   (slave -> master)
//   dbg_state    encoded FSM state                   (slave -> master)
//   dbg_prev     last accepted sample                (slave -> master)
//   cap_expected / cap_actual   first-error capture (only with the
//                SEQ_CHK_CAPTURE_EN macro defined)
//
// Handshake: count_in is sampled on a rising clk edge only when in_valid is
// high; there is no ready, the checker accepts every qualified cycle.
// ---------------------------------------------------------------------------
interface count_seq_checker_if #(
  parameter int WIDTH      = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8
);
  logic                  in_valid;
  logic [WIDTH-1:0]      count_in;
  logic                  locked;
  logic                  err_pulse;
  logic                  error;
  logic [ERR_CNT_W-1:0]  err_count;
  logic                  wrap_pulse;
  logic [WRAP_CNT_W-1:0] wrap_count;
  logic [1:0]            dbg_state;
  logic [WIDTH-1:0]      dbg_prev;
`ifdef SEQ_CHK_CAPTURE_EN
  logic [WIDTH-1:0]      cap_expected;
  logic [WIDTH-1:0]      cap_actual;
`endif

  modport master (
    output in_valid, count_in,
    input  locked, err_pulse, error, err_count, wrap_pulse, wrap_count,
    input  dbg_state, dbg_prev
`ifdef SEQ_CHK_CAPTURE_EN
    , input cap_expected, cap_actual
`endif
  );

  modport slave (
    input  in_valid, count_in,
    output locked, err_pulse, error, err_count, wrap_pulse, wrap_count,
    output dbg_state, dbg_prev
`ifdef SEQ_CHK_CAPTURE_EN
    , output cap_expected, cap_actual
`endif
  );
endinterface

// File: rtl/count_seq_checker.sv
// ---------------------------------------------------------------------------
// count_seq_checker
// Passive monitor for an up-counter bus. Each qualified sample must be the
// previous accepted sample (stall) or previous+1 modulo 2^WIDTH. Reports lock
// status, legal wraps and sequence errors. Never drives the counter.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (priority over everything)
//   bus   count_seq_checker_if.slave: in_valid/count_in in; locked,
//         err_pulse, error, err_count, wrap_pulse, wrap_count, dbg_state,
//         dbg_prev out.
//
// Optional feature: define SEQ_CHK_CAPTURE_EN to add cap_expected/cap_actual,
// which latch the expected and observed values of the first error after reset.
// ---------------------------------------------------------------------------
module count_seq_checker #(
  parameter int WIDTH      = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8
) (
  input logic clk,
  input logic rst,
  count_seq_checker_if.slave bus
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    RESYNC   = 2'd2
  } state_t;

  state_t                r_state;
  logic [WIDTH-1:0]      r_prev;
  logic                  r_err_pulse;
  logic                  r_error;
  logic [ERR_CNT_W-1:0]  r_err_count;
  logic                  r_wrap_pulse;
  logic [WRAP_CNT_W-1:0] r_wrap_count;
`ifdef SEQ_CHK_CAPTURE_EN
  logic [WIDTH-1:0]      r_cap_expected;
  logic [WIDTH-1:0]      r_cap_actual;
`endif

  logic [WIDTH-1:0] w_expected;
  logic             w_stall;
  logic             w_match;
  logic             w_wrap;

  // Carry out of the increment is dropped, giving the modulo wrap for free.
  assign w_expected = r_prev + {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_stall    = (bus.count_in == r_prev);
  assign w_match    = (bus.count_in == w_expected);
  assign w_wrap     = (r_prev == {WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= UNLOCKED;
      r_prev         <= '0;
      r_err_pulse    <= 1'b0;
      r_error        <= 1'b0;
      r_err_count    <= '0;
      r_wrap_pulse   <= 1'b0;
      r_wrap_count   <= '0;
`ifdef SEQ_CHK_CAPTURE_EN
      r_cap_expected <= '0;
      r_cap_actual   <= '0;
`endif
    end else begin
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      if (bus.in_valid) begin
        case (r_state)
          // The very first sample after reset always locks, even when it
          // happens to equal the reset value of prev.
          UNLOCKED: begin
            r_prev  <= bus.count_in;
            r_state <= LOCKED;
          end
          LOCKED: begin
            if (w_stall) begin
              r_state <= LOCKED;
            end else if (w_match) begin
              r_prev <= bus.count_in;
              if (w_wrap) begin
                r_wrap_pulse <= 1'b1;
                r_wrap_count <= r_wrap_count + 1'b1;
              end
            end else begin
              r_err_pulse <= 1'b1;
              r_error     <= 1'b1;
              if (r_err_count != {ERR_CNT_W{1'b1}})
                r_err_count <= r_err_count + 1'b1;
`ifdef SEQ_CHK_CAPTURE_EN
              // Sticky error still clear means this is the first error.
              if (!r_error) begin
                r_cap_expected <= w_expected;
                r_cap_actual   <= bus.count_in;
              end
`endif
              r_prev  <= bus.count_in;
              r_state <= RESYNC;
            end
          end
          RESYNC: begin
            if (w_stall) begin
              r_state <= RESYNC;
            end else if (w_match) begin
              r_prev  <= bus.count_in;
              r_state <= LOCKED;
              if (w_wrap) begin
                r_wrap_pulse <= 1'b1;
                r_wrap_count <= r_wrap_count + 1'b1;
              end
            end else begin
              // Keep following the counter; one error per loss of lock.
              r_prev <= bus.count_in;
            end
          end
          default: r_state <= UNLOCKED;
        endcase
      end
    end
  end

  assign bus.locked     = (r_state == LOCKED);
  assign bus.err_pulse  = r_err_pulse;
  assign bus.error      = r_error;
  assign bus.err_count  = r_err_count;
  assign bus.wrap_pulse = r_wrap_pulse;
  assign bus.wrap_count = r_wrap_count;
  assign bus.dbg_state  = r_state;
  assign bus.dbg_prev   = r_prev;
`ifdef SEQ_CHK_CAPTURE_EN
  assign bus.cap_expected = r_cap_expected;
  assign bus.cap_actual   = r_cap_actual;
`endif

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
Downstream monitor for the synchronous up-counter output (4-bit count bus). It samples the count each qualified cycle and checks that it advances by exactly +1 modulo 2^WIDTH. It reports lock status, wrap-around events and sequence errors to the lab's status LEDs and testbenches. It is purely an observer and never drives the counter.

Parameters:
WIDTH, 4, width of the observed count bus
ERR_CNT_W, 8, width of the saturating error counter
WRAP_CNT_W, 8, width of the wrap counter (modulo, not saturating)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  qualifies count_in this cycle
count_in  input  WIDTH  observed counter value
locked  output  1  high while FSM is in LOCKED
err_pulse  output  1  one-cycle pulse per detected sequence error
error  output  1  sticky error flag, cleared only by rst
err_count  output  ERR_CNT_W  number of errors, saturates at all-ones
wrap_pulse  output  1  one-cycle pulse on legal max->0 transition
wrap_count  output  WRAP_CNT_W  number of legal wraps, modulo 2^WRAP_CNT_W

Behaviour:
- Single clock domain (clk). rst is synchronous and active-high. All outputs are registered.
- Reset values: FSM=UNLOCKED, prev=0, locked=0, err_pulse=0, error=0, err_count=0, wrap_pulse=0, wrap_count=0.
- rst has priority over every other event. Asserting rst mid-operation clears all state on that edge.
- Register prev holds the last accepted sample. expected = (prev + 1) mod 2^WIDTH; the carry is discarded.
- Cycles with in_valid=0 are ignored: state, prev and counters hold, and pulses deassert.
- A sample with in_valid=1 and count_in==prev is a stall. It is legal in every state: no update, no pulse.
- FSM states:
  - UNLOCKED: first valid sample loads prev, goes to LOCKED, and is not checked.
  - LOCKED, count_in==expected: prev<=count_in, stay LOCKED. If prev==2^WIDTH-1 (count_in==0), assert wrap_pulse and increment wrap_count.
  - LOCKED, count_in is neither expected nor prev: assert err_pulse, set error=1, err_count+1 (saturating), prev<=count_in, go to RESYNC.
  - RESYNC, count_in==expected: prev<=count_in, go to LOCKED. A wrap here also pulses wrap_pulse.
  - RESYNC, mismatch: prev<=count_in, stay RESYNC. No additional error is counted.
- Latency: pulses and counter updates appear on the clk edge after the sampled cycle, i.e. one cycle after the edge that presents count_in.
- err_count at all-ones stays all-ones, and err_pulse still fires. wrap_count rolls over to 0.
- locked is combinationally equal to state==LOCKED, taken from the state register.

Optional Feature:
Macro SEQ_CHK_CAPTURE_EN.
- Defined: adds output ports cap_expected[WIDTH] and cap_actual[WIDTH], both reset to 0. On the first error after reset only, they latch expected and count_in. They then hold until rst.
- Undefined: these ports and their registers do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset then count 0..15,0,1 with in_valid=1 every cycle -> locked=1 from the cycle after the first sample, one wrap_pulse after the 15->0 sample, wrap_count=1, error=0, err_count=0.
- Locked at 5, then apply 9 -> err_pulse for one cycle, error=1, err_count=1, locked=0. Then apply 10 -> locked=1 again, err_count stays 1. With SEQ_CHK_CAPTURE_EN: cap_expected=6, cap_actual=9.
- Apply 3,3,3 then 4, with in_valid gaps between them -> no error, locked stays 1, prev=4, no pulses during gaps.
- Apply 300 errors, each bad value followed by a good resync -> err_count=255 saturated, err_pulse still seen on each error.
- Assert rst for one cycle mid-count at value 12 -> all outputs 0 next cycle. The next sample, e.g. 7, relocks with no error.
- Run 512 wraps -> wrap_count returns to 0 (WRAP_CNT_W=8), error=0.
